// File: rtl/fetch_unit_pkg.sv
// Shared types and constants for the instruction-fetch stage.
// Holds the FSM state encoding, reset/NOP constants and the PC word-align helper.
package fetch_unit_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_HOLD = 2'd2,
    FETCH_DROP = 2'd3
  } fetch_state_t;

  localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;
  localparam logic        RST_ENABLE = 1'b1;
  localparam logic [31:0] NOP_INST   = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_skid.sv
// One-entry {pc, inst} buffer that parks an instruction returned while decode is stalled.
// A clear has priority over a load so a redirect always empties the entry.
module fetch_skid
  import fetch_unit_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_pc,
  input  logic [31:0] i_inst,
  output logic        o_valid,
  output logic [31:0] o_pc,
  output logic [31:0] o_inst
);

  logic        r_valid;
  logic [31:0] r_pc;
  logic [31:0] r_inst;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_valid <= 1'b0;
      r_pc    <= ZERO_WORD;
      r_inst  <= NOP_INST;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_pc    <= i_pc;
      r_inst  <= i_inst;
    end
  end

  assign o_valid = r_valid;
  assign o_pc    = r_pc;
  assign o_inst  = r_inst;

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, runs the imem req/ack handshake and feeds
// decode through a registered {pc, inst, valid} stage with stall, redirect and skid.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         stall_i,
  input  logic         flush_i,
  input  logic [31:0]  new_pc_i,
  output logic         imem_req_o,
  output logic [31:0]  imem_addr_o,
  input  logic         imem_ack_i,
  input  logic [31:0]  imem_rdata_i,
  output logic [31:0]  id_pc_o,
  output logic [31:0]  id_inst_o,
  output logic         id_valid_o,
  output fetch_state_t dbg_state_o
);

  // Handshake: a transfer completes on any rising edge where imem_req_o=1 and
  // imem_ack_i=1; imem_addr_o holds steady from request until that edge.

  fetch_state_t r_state;
  fetch_state_t w_next_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_old_pc;
  logic [31:0]  r_id_pc;
  logic [31:0]  r_id_inst;
  logic         r_id_valid;
  logic         w_accept;
  logic         w_skid_load;
  logic         w_skid_clear;
  logic         w_skid_valid;
  logic [31:0]  w_skid_pc;
  logic [31:0]  w_skid_inst;

  always_comb begin
    w_next_state = r_state;
    w_accept     = (r_state == FETCH_REQ) && imem_ack_i;
    w_skid_load  = w_accept && !flush_i && stall_i;
    w_skid_clear = flush_i || ((r_state == FETCH_HOLD) && !stall_i);
    case (r_state)
      FETCH_IDLE: w_next_state = FETCH_REQ;
      FETCH_REQ: begin
        if (flush_i)                  w_next_state = imem_ack_i ? FETCH_REQ : FETCH_DROP;
        else if (imem_ack_i && stall_i) w_next_state = FETCH_HOLD;
      end
      FETCH_HOLD: begin
        if (flush_i || !stall_i) w_next_state = FETCH_REQ;
      end
      // A redirect here only retargets the PC; the old request still has to drain.
      FETCH_DROP: begin
        if (imem_ack_i) w_next_state = FETCH_REQ;
      end
      default: w_next_state = FETCH_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) r_state <= FETCH_IDLE;
    else                   r_state <= w_next_state;
  end

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      r_pc       <= RESET_PC;
      r_old_pc   <= ZERO_WORD;
      r_id_pc    <= ZERO_WORD;
      r_id_inst  <= NOP_INST;
      r_id_valid <= 1'b0;
    end else begin
      if (flush_i) begin
        r_pc <= word_align(new_pc_i);
        if ((r_state == FETCH_REQ) && !imem_ack_i) r_old_pc <= r_pc;
      end else if (w_accept) begin
        r_pc <= r_pc + 32'd4;
      end

      if (flush_i) begin
        r_id_inst  <= NOP_INST;
        r_id_valid <= 1'b0;
      end else if (!stall_i) begin
        if (w_accept) begin
          r_id_pc    <= r_pc;
          r_id_inst  <= imem_rdata_i;
          r_id_valid <= 1'b1;
        end else if (r_state == FETCH_HOLD) begin
          r_id_pc    <= w_skid_pc;
          r_id_inst  <= w_skid_inst;
          r_id_valid <= w_skid_valid;
        end else begin
          r_id_inst  <= NOP_INST;
          r_id_valid <= 1'b0;
        end
      end
    end
  end

  fetch_skid u_skid (
    .clk     (clk),
    .rst     (rst),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_pc    (r_pc),
    .i_inst  (imem_rdata_i),
    .o_valid (w_skid_valid),
    .o_pc    (w_skid_pc),
    .o_inst  (w_skid_inst)
  );

  assign imem_req_o  = (r_state == FETCH_REQ) || (r_state == FETCH_DROP);
  assign imem_addr_o = (r_state == FETCH_DROP) ? r_old_pc : r_pc;
  assign id_pc_o     = r_id_pc;
  assign id_inst_o   = r_id_inst;
  assign id_valid_o  = r_id_valid;
  assign dbg_state_o = r_state;

endmodule
